// File: rtl/mul_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the multiplier arbiter.
package mul_arb_pkg;

    localparam int OP_W    = 4;
    localparam int RES_W   = 2 * OP_W;
    localparam int MAX_REQ = 4;

    // Operand pair carried through the single pipeline stage.
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operands_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // One-hot grant for the first eligible index at or after ptr, wrapping mod nreq.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] elig,
        input logic [1:0]         ptr,
        input int                 nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic [1:0]         idx;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int off = 0; off < MAX_REQ; off++) begin
            idx = 2'((int'(ptr) + off) % nreq);
            if (!found && (off < nreq) && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mul4x4_addtree.sv
// Combinational 4x4 unsigned multiplier: four shifted partial products summed
// by a two-level adder tree.
module mul4x4_addtree
    import mul_arb_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] p
);

    logic [RES_W-1:0] pp [OP_W];
    logic [RES_W-1:0] sum_lo;
    logic [RES_W-1:0] sum_hi;

    // Partial product i is a shifted left by i, gated by bit i of b.
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            pp[i] = b[i] ? (RES_W'(a) << i) : '0;
        end
    end

    // Two-level tree; 15*15 = 225 fits in RES_W so no carry is lost.
    assign sum_lo = pp[0] + pp[1];
    assign sum_hi = pp[2] + pp[3];
    assign p      = sum_lo + sum_hi;

endmodule

// File: rtl/mul_rr_arbiter.sv
// Shares one 4x4 multiplier among NREQ requesters with round-robin arbitration,
// one accept per cycle, a single operand stage and a result slot per requester.
module mul_rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*OP_W-1:0]  req_a,
    input  logic [NREQ*OP_W-1:0]  req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NREQ*RES_W-1:0] rsp_prod,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic                  busy
);

    localparam int TAG_W = tag_w(NREQ);

    logic               vld_p1;
    logic [TAG_W-1:0]   tag_p1;
    operands_t          ops_p1;
    logic [TAG_W-1:0]   ptr;
    logic [NREQ-1:0]    inflight;
    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant;
    logic [MAX_REQ-1:0] elig_w;
    logic [MAX_REQ-1:0] grant_w;
    logic               accept;
    logic [TAG_W-1:0]   accept_tag;
    operands_t          accept_ops;
    logic [RES_W-1:0]   product;
    logic               unused_grant;

    // A requester is blocked while its operation sits in stage 1, and while its
    // slot is full unless that slot is being consumed this cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            inflight[i] = vld_p1 && (tag_p1 == TAG_W'(i));
        end
    end

    assign elig = req_valid & ~inflight & (~rsp_valid | rsp_ready);

    // Round-robin choice; ready is also forced low while reset is asserted.
    always_comb begin
        elig_w            = '0;
        elig_w[NREQ-1:0]  = elig;
        grant_w           = rr_pick(elig_w, 2'(ptr), NREQ);
        grant             = grant_w[NREQ-1:0] & {NREQ{ena & rst_n}};
    end

    assign unused_grant = ^grant_w;
    assign req_ready    = grant;
    assign accept       = |grant;

    // Encode the winning index and mux its operands into stage 1.
    always_comb begin
        accept_tag = '0;
        accept_ops = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                accept_tag   = TAG_W'(i);
                accept_ops.a = req_a[i*OP_W +: OP_W];
                accept_ops.b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Stage 1: capture the accepted operands and owner tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            tag_p1 <= '0;
            ops_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                tag_p1 <= accept_tag;
                ops_p1 <= accept_ops;
            end
        end
    end

    // Priority pointer moves just past the last winner; frozen when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (accept_tag == TAG_W'(NREQ - 1)) ? '0 : accept_tag + 1'b1;
        end
    end

    mul4x4_addtree u_mul (
        .a (ops_p1.a),
        .b (ops_p1.b),
        .p (product)
    );

    // Result slots: fill from stage 1, clear on consumer handshake, hold data otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_prod  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (vld_p1 && (tag_p1 == TAG_W'(i))) begin
                    rsp_valid[i]                <= 1'b1;
                    rsp_prod[i*RES_W +: RES_W]  <= product;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = vld_p1 | (|rsp_valid);

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Self-checking bench for mul_rr_arbiter: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mul_rr_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*4-1:0] req_a = '0;
    logic [N*4-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N*8-1:0] rsp_prod;
    logic [N-1:0]   rsp_ready = '0;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ptr;
    bit m_sv [N];
    int m_sp [N];
    int pend_tag [$];
    int pend_prod [$];
    int last_grant;
    bit sb_on = 1'b0;
    int exp_q [$];

    typedef struct {
        int         req;
        int         a;
        int         b;
        logic [1:0] exp_ready;
        int         exp_prod;
    } vec_t;

    mul_rr_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_prod  (rsp_prod),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d req=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_inflight(input int k);
        foreach (pend_tag[j]) if (pend_tag[j] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pick();
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (req_valid[k] && !m_inflight(k) && (!m_sv[k] || rsp_ready[k])) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int           p;
        r = '0;
        p = m_pick();
        if (ena && rst_n && p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    function automatic bit m_busy();
        bit b;
        b = (pend_tag.size() > 0);
        for (int i = 0; i < N; i++) b |= m_sv[i];
        return b;
    endfunction

    task automatic m_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_sv[i] = 1'b0;
            m_sp[i] = 0;
        end
        pend_tag.delete();
        pend_prod.delete();
        last_grant = -1;
    endtask

    task automatic model_check();
        chk("req_ready", req_ready, m_ready());
        chk("busy", busy, m_busy());
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rsp_valid%0d", i), rsp_valid[i], m_sv[i]);
            chk($sformatf("rsp_prod%0d", i), rsp_prod[i*8 +: 8], m_sp[i]);
        end
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_update();
        int g;
        int lt [$];
        int lp [$];
        g = (ena && rst_n) ? m_pick() : -1;
        lt = pend_tag;
        lp = pend_prod;
        pend_tag.delete();
        pend_prod.delete();
        for (int i = 0; i < N; i++) if (m_sv[i] && rsp_ready[i]) m_sv[i] = 1'b0;
        foreach (lt[j]) begin
            m_sv[lt[j]] = 1'b1;
            m_sp[lt[j]] = lp[j];
        end
        last_grant = g;
        if (g >= 0) begin
            int prod;
            prod = int'(req_a[g*4 +: 4]) * int'(req_b[g*4 +: 4]);
            pend_tag.push_back(g);
            pend_prod.push_back(prod);
            m_ptr = (g + 1) % N;
            if (sb_on && g == 1) exp_q.push_back(prod);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        if (rst_n) model_check();
        if (sb_on && rsp_valid[1] && rsp_ready[1]) begin
            if (exp_q.size() == 0) begin
                chk("order_extra_result", 1, 0);
            end else begin
                chk("order_prod1", rsp_prod[15:8], exp_q.pop_front());
            end
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            at_neg();
            at_pos();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        at_pos();
    endtask

    initial begin
        vec_t tbl [6];
        int   g1;
        bit   seen0;
        bit   accepted;
        int   waitc;

        tbl[0] = '{0, 3, 5, 2'b01, 15};
        tbl[1] = '{1, 7, 9, 2'b10, 63};
        tbl[2] = '{0, 15, 15, 2'b01, 225};
        tbl[3] = '{1, 0, 9, 2'b10, 0};
        tbl[4] = '{0, 6, 4, 2'b01, 24};
        tbl[5] = '{1, 15, 1, 2'b10, 15};

        // Reset state, with valid and ena high so ready must be forced off
        m_reset();
        req_valid = 2'b11;
        ena       = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_prod", rsp_prod, 0);
        chk("rst_busy", busy, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        at_pos();

        // Single operations from the table
        rsp_ready = 2'b11;
        foreach (tbl[k]) begin
            req_valid = '0;
            req_valid[tbl[k].req] = 1'b1;
            req_a[tbl[k].req*4 +: 4] = 4'(tbl[k].a);
            req_b[tbl[k].req*4 +: 4] = 4'(tbl[k].b);
            at_neg();
            chk("t1_ready", req_ready, tbl[k].exp_ready);
            at_pos();
            req_valid = '0;
            at_neg();
            chk("t1_busy_mid", busy, 1);
            at_pos();
            at_neg();
            chk("t1_rsp_valid", rsp_valid[tbl[k].req], 1);
            chk("t1_prod", rsp_prod[tbl[k].req*8 +: 8], tbl[k].exp_prod);
            at_pos();
            at_neg();
            chk("t1_busy_end", busy, 0);
            at_pos();
        end

        // Contention: grants alternate starting at requester 0
        do_reset();
        rsp_ready  = 2'b11;
        req_a      = {4'd7, 4'd15};
        req_b      = {4'd9, 4'd15};
        req_valid  = 2'b11;
        for (int k = 0; k < 8; k++) begin
            at_neg();
            chk("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            at_pos();
        end
        req_valid = '0;
        cyc(3);
        chk("t2_prod0", rsp_prod[7:0], 225);
        chk("t2_prod1", rsp_prod[15:8], 63);

        // Backpressure on slot 0 while requester 1 keeps being served
        rsp_ready = 2'b10;
        req_a[3:0] = 4'd5;
        req_b[3:0] = 4'd5;
        req_valid  = 2'b11;
        g1 = 0;
        seen0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            at_neg();
            if (seen0) chk("t3_ready0_blocked", req_ready[0], 0);
            if (seen0 && rsp_valid[0]) chk("t3_prod0_stable", rsp_prod[7:0], 25);
            at_pos();
            if (last_grant == 0) seen0 = 1'b1;
            if (last_grant == 1) begin
                g1++;
                req_a[7:4] = 4'($urandom_range(0, 15));
                req_b[7:4] = 4'($urandom_range(0, 15));
            end
        end
        chk("t3_req1_served", (g1 >= 5), 1);
        req_valid = '0;
        rsp_ready = 2'b11;
        cyc(4);

        // ena drop right after an accept
        rsp_ready  = 2'b00;
        req_a[3:0] = 4'd6;
        req_b[3:0] = 4'd4;
        req_valid  = 2'b01;
        at_neg();
        chk("t4_ready", req_ready, 2'b01);
        at_pos();
        ena       = 1'b0;
        req_valid = 2'b11;
        at_neg();
        chk("t4_ready_off", req_ready, 0);
        chk("t4_busy", busy, 1);
        at_pos();
        at_neg();
        chk("t4_rsp_valid", rsp_valid, 2'b01);
        chk("t4_prod", rsp_prod[7:0], 24);
        chk("t4_ready_off2", req_ready, 0);
        at_pos();
        rsp_ready = 2'b01;
        at_neg();
        at_pos();
        at_neg();
        chk("t4_busy_fall", busy, 0);
        chk("t4_ready_off3", req_ready, 0);
        at_pos();
        req_valid = '0;
        ena       = 1'b1;

        // Reset while stage 1 holds an operation
        rsp_ready  = 2'b11;
        req_a[3:0] = 4'd2;
        req_b[3:0] = 4'd3;
        req_valid  = 2'b01;
        at_neg();
        chk("t5_ready", req_ready, 2'b01);
        at_pos();
        chk("t5_busy_pre", busy, 1);
        #2;
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        chk("t5_rsp_valid_async", rsp_valid, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_ready_async", req_ready, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_first_grant", req_ready, 2'b01);
        model_check();
        at_pos();
        req_valid = '0;
        cyc(3);

        // Exhaustive operand sweep through requester 1 with random rsp_ready
        sb_on     = 1'b1;
        req_valid = 2'b10;
        for (int p = 0; p < 256; p++) begin
            req_a[7:4] = 4'(p >> 4);
            req_b[7:4] = 4'(p & 15);
            accepted = 1'b0;
            waitc    = 0;
            while (!accepted && waitc < 20) begin
                rsp_ready = 2'($urandom);
                at_neg();
                at_pos();
                accepted = (last_grant == 1);
                waitc++;
            end
            chk("t6_accept", accepted, 1);
            if (!accepted) break;
        end
        req_valid = '0;
        rsp_ready = 2'b11;
        cyc(4);
        chk("t6_drained", exp_q.size(), 0);
        sb_on = 1'b0;

        // Random traffic on both requesters
        for (int k = 0; k < 400; k++) begin
            ena       = ($urandom_range(0, 9) != 0);
            rsp_ready = 2'($urandom);
            at_neg();
            at_pos();
            for (int i = 0; i < N; i++) begin
                if (last_grant == i || !req_valid[i]) begin
                    req_valid[i]   = 1'($urandom);
                    req_a[i*4 +: 4] = 4'($urandom_range(0, 15));
                    req_b[i*4 +: 4] = 4'($urandom_range(0, 15));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        ena       = 1'b1;
        rsp_ready = 2'b11;
        cyc(4);
        chk("end_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
